crc8_checker: RTL
=================

Name: crc8_checker

Overview:
Receive-side counterpart of the crc8 generator. It accepts a byte stream framed by valid/last, where the final byte of each frame is the transmitted CRC-8. It strips that trailing CRC byte and forwards the payload one byte behind. It reports a per-frame check result: CRC match, runt or overlong. It sits between the link deserializer and the packet consumer, in the same POLYNOMIAL domain as crc8.

Parameters:
POLYNOMIAL, 8'h07, CRC-8 generator polynomial; normal MSB-first form, no reflection, no final XOR; must equal the transmitter's.
INIT, 8'h00, CRC register value at start of each frame.
MAX_LEN, 256, maximum frame length in bytes, CRC byte included; range 2..65535.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
data_i  input  8  incoming byte
data_valid_i  input  1  data_i valid this cycle; no backpressure
data_last_i  input  1  qualifies data_i as the frame's final (CRC) byte
data_o  output  8  forwarded payload byte
data_valid_o  output  1  data_o valid
data_last_o  output  1  data_o is the last payload byte of the frame
check_valid_o  output  1  one-cycle pulse: frame result available
crc_ok_o  output  1  frame passed CRC; meaningful only with check_valid_o
runt_o  output  1  frame had fewer than 2 bytes; qualified by check_valid_o
overlong_o  output  1  frame exceeded MAX_LEN; qualified by check_valid_o

Behaviour:
- Reset: one clock, synchronous, active-high; rst_i sampled on rising clk_i. Every output is 0, crc reg = INIT, hold buffer empty, byte count 0, state IDLE. Reset mid-frame abandons the frame: no check pulse and no flush of the held byte.
- CRC arithmetic: crc_next = crc8_step(crc, byte), 8 MSB-first shift/XOR iterations with POLYNOMIAL. It runs over every byte including the received CRC byte.
- Pass condition: final residue == 8'h00. This is valid for any INIT because there is no final XOR.
- Hold buffer: one byte plus a full flag.
  - On an accepted non-last byte with the buffer full, the buffered byte is emitted next cycle (data_valid_o=1, data_last_o=0) and the new byte is buffered.
  - The CRC byte is never forwarded.
- Latency: payload byte N appears on data_o one cycle after byte N+1 is accepted.
- States:
  - IDLE: first valid byte sets count=1, crc=crc8_step(INIT, byte). If last, go to the runt result; else go to ACTIVE.
  - ACTIVE: each valid byte increments count. On last, go to result. If count would exceed MAX_LEN without last, go to DISCARD.
  - DISCARD: drop bytes until last. The buffered byte is emitted with data_last_o=1 on entry, so the consumer sees a closed frame. On last: check_valid_o=1, overlong_o=1, crc_ok_o=0.
- Result cycle (the cycle after last is accepted):
  - check_valid_o=1.
  - crc_ok_o = (residue==0) and not runt/overlong.
  - The held payload byte is emitted with data_last_o=1 in the same cycle.
  - Runt (single-byte frame): no payload emitted, runt_o=1, crc_ok_o=0.
  - Return to IDLE.
- Back-to-back frames: a first byte of the next frame arriving in the result cycle is accepted. crc reinitialises from INIT, not from the old residue.
- data_valid_i=0 gaps are allowed anywhere and hold all state.
- data_last_i is ignored when data_valid_i=0.
- Count saturates; no wrap.

Decomposition:
- crc8_pkg: function crc8_step(crc, byte, poly) shared with crc8 (crc8 refactored to call it); state enum {IDLE, ACTIVE, DISCARD}; CRC_WIDTH=8 constant.
- No sub-module; single flat module.
- Formal companion crc8_checker_properties plus a top that wires crc8 output into crc8_checker, proving any frame built by the generator yields crc_ok_o.

Test Plan:
- Frame 0x01,0x07(last) -> data_o=0x01 with data_last_o=1 in result cycle; check_valid_o=1, crc_ok_o=1.
- ASCII "123456789" then 0xF4(last) -> nine payload bytes in order, last flagged on 0x39; crc_ok_o=1.
- Frame 0x01,0x06(last) -> payload 0x01 forwarded; crc_ok_o=0, runt_o=0, overlong_o=0.
- Single byte 0x00 with last -> no data_valid_o; check_valid_o=1, runt_o=1, crc_ok_o=0.
- MAX_LEN=4, six bytes then last -> three payload bytes, third carries data_last_o=1; later check pulse with overlong_o=1; remainder dropped.
- Two frames back-to-back (0x01,0x07 then 0x00,0x00) with no idle cycle, plus rst_i pulsed mid-third-frame -> two crc_ok_o pulses, nothing from the third frame, all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/crc8_pkg.sv
// crc8_pkg: shared CRC-8 step function, width constant and checker state encoding
package crc8_pkg;
  localparam int CRC_WIDTH = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t ACTIVE  = 2'd1;
  localparam state_t DISCARD = 2'd2;
  function automatic logic [CRC_WIDTH-1:0] crc8_step(
    input logic [CRC_WIDTH-1:0] crc,
    input logic [7:0]           data,
    input logic [CRC_WIDTH-1:0] poly
  );
    logic [CRC_WIDTH-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ poly : {c[6:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/crc8_checker.sv
// crc8_checker: strips the trailing CRC-8 byte of each valid/last frame, forwards the payload one byte behind and pulses a per-frame ok/runt/overlong result
module crc8_checker
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] INIT       = 8'h00,
  parameter int         MAX_LEN    = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       data_last_o,
  output logic       check_valid_o,
  output logic       crc_ok_o,
  output logic       runt_o,
  output logic       overlong_o
);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  state_t      state_q;
  logic [7:0]  crc_q, hold_q, crc_nx;
  logic        full_q, over;
  logic [15:0] count_q, count_nx;
  always_comb begin
    crc_nx   = crc8_step(state_q == IDLE ? INIT : crc_q, data_i, POLYNOMIAL);
    count_nx = state_q == IDLE ? 16'd1 : count_q == 16'hFFFF ? count_q : count_q + 16'd1;
    // reaching MAX_LEN on a non-last byte already proves the frame too long
    over     = count_nx >= MAX_LEN_W;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      crc_q         <= INIT;
      hold_q        <= 8'h00;
      full_q        <= 1'b0;
      count_q       <= 16'd0;
      data_o        <= 8'h00;
      data_valid_o  <= 1'b0;
      data_last_o   <= 1'b0;
      check_valid_o <= 1'b0;
      crc_ok_o      <= 1'b0;
      runt_o        <= 1'b0;
      overlong_o    <= 1'b0;
    end else begin
      data_valid_o  <= 1'b0;
      data_last_o   <= 1'b0;
      check_valid_o <= 1'b0;
      crc_ok_o      <= 1'b0;
      runt_o        <= 1'b0;
      overlong_o    <= 1'b0;
      if (data_valid_i) begin
        count_q <= count_nx;
        crc_q   <= crc_nx;
        case (state_q)
          IDLE: begin
            check_valid_o <= data_last_i;
            runt_o        <= data_last_i;
            hold_q        <= data_i;
            full_q        <= !data_last_i;
            state_q       <= data_last_i ? IDLE : ACTIVE;
          end
          ACTIVE: begin
            data_o        <= hold_q;
            data_valid_o  <= full_q;
            data_last_o   <= full_q && (data_last_i || over);
            hold_q        <= data_i;
            full_q        <= !(data_last_i || over);
            check_valid_o <= data_last_i;
            crc_ok_o      <= data_last_i && crc_nx == 8'h00;
            state_q       <= data_last_i ? IDLE : over ? DISCARD : ACTIVE;
          end
          DISCARD: begin
            check_valid_o <= data_last_i;
            overlong_o    <= data_last_i;
            state_q       <= data_last_i ? IDLE : DISCARD;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
